// File: rtl/ravenoc_axi_initiator.sv
// ravenoc_axi_initiator: AXI4 initiator driving one RaveNoC node slave port from a command/stream interface.
// Ports: clk_axi/arst_axi_n clock and async active-low reset; cmd_* burst command handshake;
// wr_* write beat stream in; rd_* read beat stream out; done/done_resp/len_err end-of-transaction status;
// fault sticky watchdog flag; busy non-idle; axi_mosi/axi_miso AXI4 link to the node.
`ifndef AXI_ALEN_WIDTH
`define AXI_ALEN_WIDTH 8
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

package ravenoc_axi_pkg;
  localparam int AXI_ALEN_WIDTH = `AXI_ALEN_WIDTH;
  localparam int AXI_DATA_WIDTH = `AXI_DATA_WIDTH;
  typedef logic [31:0] axi_addr_t;
  typedef logic [2:0] axi_size_t;
  typedef logic [AXI_ALEN_WIDTH-1:0] axi_alen_t;
  typedef enum logic [1:0] {FIXED, INCR, WRAP, RESERVED} axi_burst_t;
  typedef enum logic [1:0] {OKAY, EXOKAY, SLVERR, DECERR} axi_error_t;
  typedef struct packed {
    logic awid;
    axi_addr_t awaddr;
    axi_alen_t awlen;
    axi_size_t awsize;
    axi_burst_t awburst;
    logic awlock;
    logic [3:0] awcache;
    logic [2:0] awprot;
    logic [3:0] awqos;
    logic [3:0] awregion;
    logic awuser;
    logic awvalid;
    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic wlast;
    logic wuser;
    logic wvalid;
    logic bready;
    logic arid;
    axi_addr_t araddr;
    axi_alen_t arlen;
    axi_size_t arsize;
    axi_burst_t arburst;
    logic arlock;
    logic [3:0] arcache;
    logic [2:0] arprot;
    logic [3:0] arqos;
    logic [3:0] arregion;
    logic aruser;
    logic arvalid;
    logic rready;
  } s_axi_mosi_t;
  typedef struct packed {
    logic awready;
    logic wready;
    logic bid;
    axi_error_t bresp;
    logic buser;
    logic bvalid;
    logic arready;
    logic rid;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    axi_error_t rresp;
    logic rlast;
    logic ruser;
    logic rvalid;
  } s_axi_miso_t;
endpackage

module ravenoc_axi_initiator
  import ravenoc_axi_pkg::*;
#(
  parameter int TimeoutCycles = 1024,
  parameter logic AxiId = 1'b0
) (
  input  logic clk_axi,
  input  logic arst_axi_n,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_write,
  input  axi_addr_t cmd_addr,
  input  logic [`AXI_ALEN_WIDTH-1:0] cmd_len,
  input  axi_size_t cmd_size,
  input  logic [`AXI_DATA_WIDTH-1:0] wr_data,
  input  logic wr_valid,
  output logic wr_ready,
  output logic [`AXI_DATA_WIDTH-1:0] rd_data,
  output logic rd_valid,
  output logic rd_last,
  input  logic rd_ready,
  output logic done,
  output axi_error_t done_resp,
  output logic len_err,
  output logic fault,
  output logic busy,
  output s_axi_mosi_t axi_mosi,
  input  s_axi_miso_t axi_miso
);
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE, FAULT} state_t;
  localparam int WW = $clog2(TimeoutCycles);
  state_t state, next;
  axi_addr_t addr;
  axi_alen_t len;
  axi_size_t size;
  logic [AXI_ALEN_WIDTH:0] beat;
  logic [WW-1:0] wd;
  axi_error_t err;
  logic lerr, fault_seen, hs, last_beat, active, timeout;
  s_axi_mosi_t mosi_c, mosi_q;
  logic unused_miso;
  assign unused_miso = ^{axi_miso.bid, axi_miso.buser, axi_miso.rid, axi_miso.ruser};
  assign last_beat = beat == {1'b0, len};
  always_comb begin
    mosi_c = '0;
    if (state == WR_ADDR) begin
      mosi_c.awvalid = 1'b1;
      mosi_c.awid = AxiId;
      mosi_c.awaddr = addr;
      mosi_c.awlen = len;
      mosi_c.awsize = size;
      mosi_c.awburst = INCR;
    end
    if (state == WR_DATA) begin
      mosi_c.wvalid = wr_valid;
      mosi_c.wdata = wr_data;
      mosi_c.wstrb = '1;
      mosi_c.wlast = last_beat;
    end
    if (state == WR_RESP) mosi_c.bready = 1'b1;
    if (state == RD_ADDR) begin
      mosi_c.arvalid = 1'b1;
      mosi_c.arid = AxiId;
      mosi_c.araddr = addr;
      mosi_c.arlen = len;
      mosi_c.arsize = size;
      mosi_c.arburst = INCR;
    end
    if (state == RD_DATA) mosi_c.rready = rd_ready;
  end
  assign hs = (mosi_c.awvalid & axi_miso.awready) | (mosi_c.wvalid & axi_miso.wready) |
              (mosi_c.bready & axi_miso.bvalid) | (mosi_c.arvalid & axi_miso.arready) |
              (mosi_c.rready & axi_miso.rvalid);
  assign active = state inside {WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA};
  // a handshake in the expiry cycle always wins over the watchdog
  assign timeout = active && !hs && wd == WW'(TimeoutCycles - 1);
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = cmd_valid ? (cmd_write ? WR_ADDR : RD_ADDR) : IDLE;
      WR_ADDR: next = hs ? WR_DATA : WR_ADDR;
      WR_DATA: next = hs && last_beat ? WR_RESP : WR_DATA;
      WR_RESP: next = hs ? DONE : WR_RESP;
      RD_ADDR: next = hs ? RD_DATA : RD_ADDR;
      RD_DATA: next = hs && axi_miso.rlast ? DONE : RD_DATA;
      DONE:    next = IDLE;
      default: next = FAULT;
    endcase
    if (timeout) next = FAULT;
  end
  always_ff @(posedge clk_axi or negedge arst_axi_n) begin
    if (!arst_axi_n) begin
      state <= IDLE;
      addr <= '0;
      len <= '0;
      size <= '0;
      beat <= '0;
      wd <= '0;
      err <= OKAY;
      lerr <= 1'b0;
      fault_seen <= 1'b0;
      mosi_q <= '0;
    end else begin
      state <= next;
      wd <= (next != state || hs || !active) ? '0 : wd + 1'b1;
      fault_seen <= state == FAULT;
      // snapshot of the AXI outputs so FAULT never retracts a pending valid/ready
      if (state != FAULT) mosi_q <= mosi_c;
      if (state == IDLE && cmd_valid) begin
        addr <= cmd_addr;
        len <= cmd_len;
        size <= cmd_size;
        beat <= '0;
        err <= OKAY;
        lerr <= 1'b0;
      end
      if (state == WR_DATA && hs) beat <= beat + 1'b1;
      if (state == WR_RESP && hs) err <= axi_miso.bresp;
      if (state == RD_DATA && hs) begin
        beat <= beat + 1'b1;
        if (axi_miso.rresp != OKAY && err == OKAY) err <= axi_miso.rresp;
        if (axi_miso.rlast != last_beat) lerr <= 1'b1;
      end
    end
  end
  assign axi_mosi = state == FAULT ? mosi_q : mosi_c;
  assign cmd_ready = state == IDLE && arst_axi_n;
  assign wr_ready = state == WR_DATA && axi_miso.wready;
  assign rd_valid = state == RD_DATA && axi_miso.rvalid;
  assign rd_data = state == RD_DATA ? axi_miso.rdata : '0;
  assign rd_last = state == RD_DATA && axi_miso.rlast;
  assign done = state == DONE || (state == FAULT && !fault_seen);
  assign done_resp = state == FAULT ? SLVERR : err;
  assign len_err = state == DONE && lerr;
  assign fault = state == FAULT;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_ravenoc_axi_initiator.sv
// tb_ravenoc_axi_initiator: randomized self-checking bench with an AXI slave model and transaction-level reference.
module tb_ravenoc_axi_initiator;
  import ravenoc_axi_pkg::*;
  localparam int T = 64;
  logic clk = 0, rst_n = 0;
  logic cmd_valid, cmd_ready, cmd_write, wr_valid, wr_ready, rd_valid, rd_last, rd_ready;
  logic done, len_err, fault, busy;
  axi_addr_t cmd_addr;
  logic [7:0] cmd_len;
  axi_size_t cmd_size;
  logic [31:0] wr_data, rd_data;
  axi_error_t done_resp;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;
  int total = 0, bad = 0;
  logic [31:0] dat [20];
  axi_error_t rsp [20];

  always #5 clk = ~clk;

  ravenoc_axi_initiator #(.TimeoutCycles(T), .AxiId(1'b0)) dut (
    .clk_axi(clk), .arst_axi_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready), .done(done),
    .done_resp(done_resp), .len_err(len_err), .fault(fault), .busy(busy),
    .axi_mosi(mosi), .axi_miso(miso));

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0; miso = '0;
  endtask

  task automatic send_cmd(input logic w, input axi_addr_t a, input int l);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL cmd_ready_before_cmd got=%b want=1", cmd_ready); end
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = 8'(l); cmd_size = 3'd2;
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic run_write(input axi_addr_t a, input int l, input int aw_delay, input axi_error_t br, input int wprob);
    int cyc = 0, aw_n = 0, wb = 0;
    bit b_pend = 0, got = 0;
    for (int i = 0; i <= l; i++) dat[i] = $urandom;
    send_cmd(1, a, l);
    while (!got && cyc < 400) begin
      miso.awready = cyc >= aw_delay;
      miso.wready = 1'($urandom_range(0, 1));
      wr_valid = wb <= l && $urandom_range(0, 99) < wprob;
      wr_data = wb <= l ? dat[wb] : '0;
      miso.bvalid = b_pend; miso.bresp = br;
      @(negedge clk);
      total++;
      if (mosi.wvalid && aw_n == 0) begin bad++; $display("FAIL w_before_aw wvalid=%b", mosi.wvalid); end
      if (mosi.awvalid && miso.awready) begin
        aw_n++;
        total++;
        if (mosi.awaddr !== a || mosi.awlen !== 8'(l) || mosi.awburst !== INCR || mosi.awsize !== 3'd2)
          begin bad++; $display("FAIL aw_fields addr=%h len=%0d burst=%0d size=%0d want addr=%h len=%0d", mosi.awaddr, mosi.awlen, mosi.awburst, mosi.awsize, a, l); end
      end
      if (mosi.wvalid && miso.wready) begin
        total++;
        if (mosi.wdata !== dat[wb] || mosi.wlast !== (wb == l) || wr_ready !== 1'b1 || mosi.wstrb !== 4'hf)
          begin bad++; $display("FAIL w_beat%0d data=%h last=%b wr_ready=%b want data=%h last=%b", wb, mosi.wdata, mosi.wlast, wr_ready, dat[wb], wb == l); end
        wb++;
        if (wb == l + 1) b_pend = 1;
      end
      if (mosi.bready && miso.bvalid) b_pend = 0;
      if (done) begin
        got = 1;
        total++;
        if (done_resp !== br || wb !== l + 1 || aw_n !== 1)
          begin bad++; $display("FAIL write_done resp=%0d beats=%0d aw=%0d want resp=%0d beats=%0d aw=1", done_resp, wb, aw_n, br, l + 1); end
      end
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (!got) begin bad++; $display("FAIL write_timeout done never seen got=0 want=1"); end
    miso = '0; wr_valid = 0;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL write_after_done done=%b cmd_ready=%b want 0/1", done, cmd_ready); end
    @(posedge clk); #1;
  endtask

  task automatic run_read(input axi_addr_t a, input int l, input int rlast_at, input int rmode);
    int cyc = 0, ar_n = 0, rb = 0;
    bit ar_done = 0, hold = 0, got = 0;
    axi_error_t exp_resp = OKAY;
    logic exp_lerr = rlast_at != l;
    for (int i = 0; i <= rlast_at; i++) if (rsp[i] != OKAY && exp_resp == OKAY) exp_resp = rsp[i];
    send_cmd(0, a, l);
    while (!got && cyc < 400) begin
      miso.arready = 1'($urandom_range(0, 1));
      miso.rvalid = ar_done && rb <= rlast_at && (hold || $urandom_range(0, 2) != 0);
      miso.rdata = rb <= rlast_at ? dat[rb] : '0;
      miso.rresp = rb <= rlast_at ? rsp[rb] : OKAY;
      miso.rlast = rb == rlast_at;
      rd_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (mosi.arvalid && miso.arready) begin
        ar_n++;
        ar_done = 1;
        total++;
        if (mosi.araddr !== a || mosi.arlen !== 8'(l) || mosi.arburst !== INCR)
          begin bad++; $display("FAIL ar_fields addr=%h len=%0d burst=%0d want addr=%h len=%0d", mosi.araddr, mosi.arlen, mosi.arburst, a, l); end
      end
      if (miso.rvalid && rd_ready) begin
        total++;
        if (rd_valid !== 1'b1 || rd_data !== dat[rb] || rd_last !== (rb == rlast_at) || mosi.rready !== 1'b1)
          begin bad++; $display("FAIL r_beat%0d valid=%b data=%h last=%b want 1/%h/%b", rb, rd_valid, rd_data, rd_last, dat[rb], rb == rlast_at); end
        rb++;
        hold = 0;
      end else hold = miso.rvalid;
      if (!miso.rvalid) begin
        total++;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_without_rvalid got=%b want=0", rd_valid); end
      end
      if (done) begin
        got = 1;
        total++;
        if (done_resp !== exp_resp || len_err !== exp_lerr || rb !== rlast_at + 1 || ar_n !== 1)
          begin bad++; $display("FAIL read_done resp=%0d len_err=%b beats=%0d ar=%0d want resp=%0d len_err=%b beats=%0d", done_resp, len_err, rb, ar_n, exp_resp, exp_lerr, rlast_at + 1); end
      end
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (!got) begin bad++; $display("FAIL read_timeout done never seen got=0 want=1"); end
    miso = '0; rd_ready = 0;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL read_after_done done=%b cmd_ready=%b want 0/1", done, cmd_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (cmd_ready !== 0 || busy !== 0 || done !== 0 || fault !== 0 || len_err !== 0 || mosi !== '0 || wr_ready !== 0 || rd_valid !== 0)
      begin bad++; $display("FAIL reset_state cmd_ready=%b busy=%b done=%b fault=%b mosi_nonzero=%b want all 0", cmd_ready, busy, done, fault, mosi != '0); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL reset_release cmd_ready=%b busy=%b want 1/0", cmd_ready, busy); end
  endtask

  task automatic test_write_basic();
    run_write(32'h1000, 3, 2, OKAY, 100);
  endtask

  task automatic test_write_random();
    for (int k = 0; k < 6; k++)
      run_write({$urandom_range(0, 255), 4'h0}, $urandom_range(0, 7), $urandom_range(0, 3), axi_error_t'($urandom_range(0, 3)), 60);
  endtask

  task automatic test_read_single();
    dat[0] = 32'hDEADBEEF; rsp[0] = OKAY;
    run_read(32'h2000, 0, 0, 1);
  endtask

  task automatic test_read_errors();
    for (int i = 0; i < 3; i++) dat[i] = $urandom;
    rsp[0] = OKAY; rsp[1] = SLVERR; rsp[2] = DECERR;
    run_read(32'h2100, 2, 2, 2);
  endtask

  task automatic test_len_err();
    for (int i = 0; i < 4; i++) begin dat[i] = $urandom; rsp[i] = OKAY; end
    run_read(32'h2200, 3, 1, 0);
    run_read(32'h2300, 1, 2, 2);
  endtask

  task automatic test_read_random();
    for (int k = 0; k < 6; k++) begin
      int l = $urandom_range(1, 8);
      int rl = l + $urandom_range(0, 2) - 1;
      for (int i = 0; i < 20; i++) begin dat[i] = $urandom; rsp[i] = $urandom_range(0, 3) == 0 ? axi_error_t'($urandom_range(1, 3)) : OKAY; end
      run_read({$urandom_range(0, 255), 4'h0}, l, rl, 2);
    end
  endtask

  task automatic test_async_reset();
    int wb = 0, c = 0;
    send_cmd(1, 32'h3000, 7);
    miso.awready = 1; miso.wready = 1; wr_valid = 1; wr_data = 32'h11;
    while (wb < 2 && c < 50) begin
      @(negedge clk);
      if (mosi.wvalid && miso.wready) wb++;
      @(posedge clk); #1;
      c++;
    end
    total++;
    if (mosi.wvalid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL mid_burst wvalid=%b busy=%b want 1/1", mosi.wvalid, busy); end
    #1 rst_n = 0;
    #1;
    total++;
    if (mosi.awvalid !== 0 || mosi.wvalid !== 0 || mosi.arvalid !== 0 || mosi.rready !== 0 || mosi.bready !== 0 || cmd_ready !== 0 || busy !== 0)
      begin bad++; $display("FAIL async_reset aw=%b w=%b ar=%b r=%b b=%b cmd_ready=%b want all 0", mosi.awvalid, mosi.wvalid, mosi.arvalid, mosi.rready, mosi.bready, cmd_ready); end
    idle_inputs();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    run_write(32'h3100, 1, 0, OKAY, 100);
  endtask

  task automatic test_timeout();
    int n = 0;
    bit aw = 0, seen = 0;
    send_cmd(1, 32'h4000, 1);
    miso.awready = 1; miso.wready = 1; wr_valid = 0;
    for (int c = 0; c < 4 * T && !seen; c++) begin
      @(negedge clk);
      if (fault) seen = 1;
      else if (aw) n++;
      if (mosi.awvalid && miso.awready) aw = 1;
    end
    total++;
    if (!seen || n !== T || done !== 1'b1 || done_resp !== SLVERR)
      begin bad++; $display("FAIL timeout_entry fault=%b idle_cycles=%0d done=%b resp=%0d want 1/%0d/1/%0d", seen, n, done, done_resp, T, SLVERR); end
    @(posedge clk); #1;
    wr_valid = 1; cmd_valid = 1; cmd_write = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (fault !== 1 || done !== 0 || cmd_ready !== 0 || mosi.wvalid !== 0 || mosi.arvalid !== 0 || busy !== 1)
        begin bad++; $display("FAIL fault_hold fault=%b done=%b cmd_ready=%b wvalid=%b arvalid=%b want 1/0/0/0/0", fault, done, cmd_ready, mosi.wvalid, mosi.arvalid); end
    end
    idle_inputs();
    #2 rst_n = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    total++;
    if (fault !== 0 || cmd_ready !== 1) begin bad++; $display("FAIL fault_cleared fault=%b cmd_ready=%b want 0/1", fault, cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_random();
    test_read_single();
    test_read_errors();
    test_len_err();
    test_read_random();
    test_async_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ravenoc_axi_initiator.md
Name: ravenoc_axi_initiator

Overview:
- Hardware AXI4 initiator that drives one RaveNoC node's AXI slave port (s_axi_mosi_t/s_axi_miso_t) from a simple command/stream interface.
- Lets on-chip logic push flits into a NoC VC (write bursts) and drain received packets from the RX buffers (read bursts) without a testbench-side AXI VIP.
- One transaction outstanding at a time, INCR bursts only.
- Includes a per-transaction watchdog.

Parameters:
- TimeoutCycles, 1024: idle cycles (no AXI handshake) in a non-idle state before the fault is declared; must be >= 2.
- AxiId, 1'b0: value driven on awid/arid.

Ports:
- clk_axi  input  1  clock
- arst_axi_n  input  1  reset; asynchronous, active-low
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
- cmd_write  input  1  1 = write burst, 0 = read burst
- cmd_addr  input  axi_addr_t  burst start address (NoC VC/CSR map)
- cmd_len  input  `AXI_ALEN_WIDTH  beats minus 1
- cmd_size  input  axi_size_t  beat size
- wr_data  input  `AXI_DATA_WIDTH  write beat payload
- wr_valid  input  1  write beat valid
- wr_ready  output  1  write beat consumed
- rd_data  output  `AXI_DATA_WIDTH  read beat payload
- rd_valid  output  1  read beat valid
- rd_last  output  1  last read beat
- rd_ready  input  1  read beat sink ready
- done  output  1  one-cycle pulse at end of transaction
- done_resp  output  axi_error_t  final response, valid with done
- len_err  output  1  read rlast/beat-count mismatch, valid with done
- fault  output  1  watchdog expired; sticky until reset
- busy  output  1  state != IDLE
- axi_mosi  output  s_axi_mosi_t  to NoC node AXI slave
- axi_miso  input  s_axi_miso_t  from NoC node AXI slave

Behaviour:
- Reset (arst_axi_n low, async):
  - State IDLE.
  - All axi_mosi fields 0.
  - cmd_ready=0 while reset is asserted, 1 in the first cycle after release.
  - done, len_err, fault, busy, rd_valid, wr_ready = 0.
  - Beat counter, watchdog counter and error registers = 0.
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE, FAULT.
- IDLE:
  - cmd_ready=1.
  - On cmd handshake: register addr, len and size; clear beat counter and error registers.
  - Go to WR_ADDR if cmd_write, else RD_ADDR.
- Address phase (WR_ADDR/RD_ADDR):
  - awvalid/arvalid=1, driven from registers; stable until awready/arready.
  - burst=INCR, id=AxiId; lock/cache/prot/qos/region/user=0.
  - On handshake go to WR_DATA/RD_DATA. AW and W are strictly sequential; no W beat before AW completes.
- WR_DATA (combinational pass-through):
  - wvalid=wr_valid, wdata=wr_data, wr_ready=wready, wstrb all ones.
  - wlast=(beat==len).
  - Each handshake increments beat; handshake with wlast goes to WR_RESP.
  - wr_ready=0 in all other states.
- WR_RESP: bready=1. On bvalid, capture bresp and go to DONE.
- RD_DATA (pass-through):
  - rready=rd_ready, rd_valid=rvalid, rd_data=rdata, rd_last=rlast.
  - Per handshake: if rresp != OKAY and no error has been captured yet, capture rresp (first error wins).
  - len_err set if rlast arrives with beat != len, or beat == len without rlast.
  - A handshake with rlast goes to DONE. Extra beats without rlast are flagged, not dropped.
- DONE: done=1 for exactly one cycle, with captured done_resp and len_err; next state IDLE. Total overhead is one cycle between the final handshake and cmd_ready.
- Watchdog:
  - Counter clears on entry to a state and on every AXI handshake; increments otherwise in non-IDLE/DONE/FAULT states.
  - At TimeoutCycles-1, go to FAULT.
- FAULT:
  - Terminal until reset.
  - All valid/ready outputs held at their current values (no AXI retraction); cmd_ready=0.
  - fault=1; done pulses once on entry with done_resp=SLVERR.
- cmd_valid outside IDLE is ignored (not stalled, not queued).
- 4 KB boundary crossing is not checked; the command source owns address legality.
- Simultaneous rlast handshake and watchdog expiry: the handshake wins (counter cleared).

Test Plan:
- Write 4 beats to 0x1000, awready after 2 cycles, bresp OKAY -> awlen=3, one AW handshake, wlast only on beat 4, done=1 one cycle with done_resp=OKAY, cmd_ready=1 the next cycle.
- Read 1 beat (cmd_len=0) with rd_ready toggling 1/0 -> arlen=0; rdata 0xDEADBEEF delivered once only on a rvalid&&rready cycle; rd_last=1; done_resp=OKAY; len_err=0.
- Read 3 beats, rresp on beats 2 and 3 = SLVERR then DECERR -> done_resp=SLVERR.
- Read cmd_len=3 with slave asserting rlast on beat 2 -> len_err=1 at done.
- Write with wr_valid held low for TimeoutCycles cycles -> fault=1, done pulse with done_resp=SLVERR, cmd_ready stays 0 until reset.
- Assert arst_axi_n=0 mid-burst (beat 2 of 8) -> awvalid/wvalid/arvalid/rready/bready=0 immediately (asynchronously); after release cmd_ready=1 and a new 2-beat write completes normally.
